cont_disp7s: RTL and testbench
==============================

CONT_DISP7S -- requirements
Module: cont_disp7s

Interface
REQ-001 SHALL have parameter: DIV, 4, prescaler terminal count (auto-step period in clk cycles), legal range >=1.
REQ-002 SHALL have parameter: DEB, 4, debounce stability length in clk cycles, legal range >=1.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: EN  input  1  run enable; 0 freezes count and prescaler.
REQ-006 SHALL have port: MODE  input  1  0 = auto-step from prescaler, 1 = manual step from BTN.
REQ-007 SHALL have port: UP  input  1  1 = increment, 0 = decrement.
REQ-008 SHALL have port: BTN  input  1  raw asynchronous push-button, active-high, bouncy.
REQ-009 SHALL have ports: A, B, C  output  1 each  count bits MSB..LSB, driving decoder inputs A, B, C of disp7s.
REQ-010 SHALL have port: TICK  output  1  registered one-cycle pulse in the cycle a new count value is first visible.

Function
REQ-011 Count SHALL be a 3-bit register; on a step, UP=1 wraps 7->0, UP=0 wraps 0->7.
REQ-012 Prescaler SHALL count 0..DIV-1 only while EN=1 and MODE=0, hold while EN=0, clear to 0 while MODE=1.
REQ-013 Auto step SHALL occur at the edge where prescaler equals DIV-1 (prescaler returns to 0); first count change at the DIV-th edge after EN rises, then every DIV edges; DIV=1 steps every cycle.
REQ-014 BTN SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Debounce FSM SHALL have states IDLE, CHK_P, HELD, CHK_R with a stability counter dcnt.
REQ-016 IDLE: sync=1 -> CHK_P, dcnt=0; else stay.
REQ-017 CHK_P: sync=0 -> IDLE; sync=1 and dcnt=DEB-1 -> HELD plus one-cycle press pulse; else dcnt+1.
REQ-018 HELD: sync=0 -> CHK_R, dcnt=0; else stay (holding BTN SHALL never repeat steps).
REQ-019 CHK_R: sync=1 -> HELD; sync=0 and dcnt=DEB-1 -> IDLE; else dcnt+1.
REQ-020 Manual step SHALL occur on press pulse only when MODE=1 and EN=1; with BTN held steadily high from before edge 1, count changes at edge DEB+3.
REQ-021 Debounce FSM SHALL run regardless of EN and MODE; press pulses arriving while EN=0 or MODE=0 SHALL be discarded, not queued.
REQ-022 UP SHALL be sampled at the step edge; UP changes between steps SHALL not alter count.
REQ-023 TICK SHALL be 1 exactly in the cycle following each count-changing edge, else 0; at most one step per edge.

Reset
REQ-024 While rst=1 at an edge: count=000 (A=B=C=0), TICK=0, prescaler=0, synchronizer flops=0, FSM=IDLE, dcnt=0.
REQ-025 rst SHALL dominate EN, MODE, BTN at the same edge, including mid-debounce and mid-prescale; operation resumes from reset values on the first edge with rst=0.

Structure
REQ-026 Package cont_disp7s_pkg SHALL hold the debounce state enum and default DIV/DEB constants.
REQ-027 Synchronizer plus debounce FSM SHALL be sub-module antirrebote_btn (ports clk, rst, BTN in, press pulse out, parameter DEB); counter and prescaler stay in cont_disp7s.

Verification
REQ-028 rst=1 two cycles, EN=1, MODE=0, UP=1, DIV=4 -> count 0,1,...,7,0 changing every 4 edges, TICK one cycle after each change.
REQ-029 Same with UP=0 from count 0 -> 7,6,...,0; EN=0 mid-run for 10 cycles -> count and prescaler frozen, no TICK, resumes with remaining prescale.
REQ-030 MODE=1, EN=1, DEB=4, BTN bounce 1-0-1-0 one cycle each then steady high 20 cycles -> exactly one increment, TICK once; release with bounce -> no change.
REQ-031 MODE=1, BTN steady high 3 cycles then low -> no step; steady high -> count changes at edge 7 after BTN rise.
REQ-032 rst=1 during CHK_P and at prescaler=DIV-1 -> count 0, TICK 0, no step on following edge.
REQ-033 Press completed while EN=0, then EN=1 -> no step.

Source files
------------

// File: rtl/cont_disp7s_pkg.sv
// Shared types and defaults for the 3-bit display counter and its button debouncer.
package cont_disp7s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHK_P = 2'd1,
        HELD  = 2'd2,
        CHK_R = 2'd3
    } deb_state_t;

    localparam int DIV_DEFAULT = 4;
    localparam int DEB_DEFAULT = 4;
    localparam int SYNC_STAGES = 2;

    // Width of a counter that has to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/antirrebote_btn.sv
// Push-button conditioner: two-flop synchronizer followed by a press/release debounce FSM.
module antirrebote_btn
    import cont_disp7s_pkg::*;
#(
    parameter int DEB = DEB_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic BTN,
    output logic press
);

    localparam int DW = cnt_width(DEB);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEB - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_sync;
    deb_state_t             state_reg;
    logic [DW-1:0]          dcnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= BTN;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign btn_sync = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            dcnt_reg  <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (btn_sync) begin
                        state_reg <= CHK_P;
                        dcnt_reg  <= '0;
                    end
                end
                CHK_P: begin
                    if (!btn_sync) begin
                        state_reg <= IDLE;
                    end else if (dcnt_reg == DCNT_MAX) begin
                        state_reg <= HELD;
                    end else begin
                        dcnt_reg <= dcnt_reg + DW'(1);
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state_reg <= CHK_R;
                        dcnt_reg  <= '0;
                    end
                end
                CHK_R: begin
                    if (btn_sync) begin
                        state_reg <= HELD;
                    end else if (dcnt_reg == DCNT_MAX) begin
                        state_reg <= IDLE;
                    end else begin
                        dcnt_reg <= dcnt_reg + DW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    dcnt_reg  <= '0;
                end
            endcase
        end
    end

    // Decoded from registered state so the step lands on the same edge as the CHK_P->HELD move.
    assign press = (state_reg == CHK_P) && btn_sync && (dcnt_reg == DCNT_MAX);

endmodule

// File: rtl/cont_disp7s.sv
// 3-bit up/down counter feeding a 7-segment decoder, stepped by a prescaler or a debounced button.
module cont_disp7s
    import cont_disp7s_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int DEB = DEB_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic EN,
    input  logic MODE,
    input  logic UP,
    input  logic BTN,
    output logic A,
    output logic B,
    output logic C,
    output logic TICK
);

    localparam int PW = cnt_width(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0] pre_reg;
    logic [2:0]    count_reg;
    logic [2:0]    count_next;
    logic          tick_reg;
    logic          press;
    logic          auto_step;
    logic          man_step;
    logic          step;

    antirrebote_btn #(
        .DEB(DEB)
    ) u_antirrebote (
        .clk  (clk),
        .rst  (rst),
        .BTN  (BTN),
        .press(press)
    );

    assign auto_step  = EN && !MODE && (pre_reg == PRE_MAX);
    // Presses seen while disabled or in auto mode are simply dropped.
    assign man_step   = EN && MODE && press;
    assign step       = auto_step || man_step;
    assign count_next = UP ? count_reg + 3'd1 : count_reg - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg   <= '0;
            count_reg <= 3'd0;
            tick_reg  <= 1'b0;
        end else begin
            if (MODE) begin
                pre_reg <= '0;
            end else if (EN) begin
                pre_reg <= (pre_reg == PRE_MAX) ? '0 : pre_reg + PW'(1);
            end
            if (step) begin
                count_reg <= count_next;
            end
            tick_reg <= step;
        end
    end

    assign A    = count_reg[2];
    assign B    = count_reg[1];
    assign C    = count_reg[0];
    assign TICK = tick_reg;

endmodule

// File: tb/tb_cont_disp7s.sv
// Directed bench for cont_disp7s with DIV=4, DEB=4: auto stepping, freeze, debounce and reset cases.
module tb_cont_disp7s;

    logic clk = 1'b0;
    logic rst, EN, MODE, UP, BTN;
    logic A, B, C, TICK;

    int errors = 0;
    int checks = 0;

    cont_disp7s #(
        .DIV(4),
        .DEB(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .EN  (EN),
        .MODE(MODE),
        .UP  (UP),
        .BTN (BTN),
        .A   (A),
        .B   (B),
        .C   (C),
        .TICK(TICK)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it; inputs change and outputs are sampled here.
    task automatic tick_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [2:0] obs;
        rst = 1'b1; EN = 1'b0; MODE = 1'b0; UP = 1'b1; BTN = 1'b0;
        tick_clk;
        tick_clk;
        obs = {A, B, C};
        checks++;
        if (obs !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d want=0", obs);
        end
        checks++;
        if (TICK !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got=%b want=0", TICK);
        end
        // Reset must win over an enable arriving at the same edge.
        EN = 1'b1; BTN = 1'b1;
        tick_clk;
        obs = {A, B, C};
        checks++;
        if (obs !== 3'd0 || TICK !== 1'b0) begin
            errors++;
            $display("FAIL reset_dominates count=%0d tick=%b want 0/0", obs, TICK);
        end
        BTN = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_auto_up;
        logic [2:0] obs;
        logic [2:0] exp_cnt;
        logic       exp_tick;
        rst = 1'b0; EN = 1'b1; MODE = 1'b0; UP = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick_clk;
            obs      = {A, B, C};
            exp_cnt  = 3'((e / 4) % 8);
            exp_tick = (e % 4 == 0);
            checks++;
            if (obs !== exp_cnt) begin
                errors++;
                $display("FAIL auto_up_count edge=%0d got=%0d want=%0d", e, obs, exp_cnt);
            end
            checks++;
            if (TICK !== exp_tick) begin
                errors++;
                $display("FAIL auto_up_tick edge=%0d got=%b want=%b", e, TICK, exp_tick);
            end
        end
        $display("test_auto_up done");
    endtask

    task automatic test_auto_down_freeze;
        logic [2:0] obs;
        logic [2:0] exp_cnt;
        logic       exp_tick;
        UP = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick_clk;
            obs      = {A, B, C};
            exp_cnt  = (e >= 4) ? 3'd7 : 3'd0;
            exp_tick = (e == 4);
            checks++;
            if (obs !== exp_cnt || TICK !== exp_tick) begin
                errors++;
                $display("FAIL auto_down_wrap edge=%0d count=%0d tick=%b want %0d/%b",
                         e, obs, TICK, exp_cnt, exp_tick);
            end
        end
        // Prescaler is at 2 here; hold it for 10 edges.
        EN = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick_clk;
            obs = {A, B, C};
            checks++;
            if (obs !== 3'd7 || TICK !== 1'b0) begin
                errors++;
                $display("FAIL freeze edge=%0d count=%0d tick=%b want 7/0", e, obs, TICK);
            end
        end
        EN = 1'b1;
        for (int r = 1; r <= 26; r++) begin
            tick_clk;
            obs      = {A, B, C};
            exp_cnt  = 3'(7 - (r + 2) / 4);
            exp_tick = ((r + 2) % 4 == 0);
            checks++;
            if (obs !== exp_cnt || TICK !== exp_tick) begin
                errors++;
                $display("FAIL auto_down_resume edge=%0d count=%0d tick=%b want %0d/%b",
                         r, obs, TICK, exp_cnt, exp_tick);
            end
        end
        $display("test_auto_down_freeze done");
    endtask

    task automatic test_manual_bounce;
        logic [2:0] obs;
        logic [2:0] exp_cnt;
        logic       exp_tick;
        int         ticks_seen;
        ticks_seen = 0;
        MODE = 1'b1; EN = 1'b1; UP = 1'b1;
        for (int n = 1; n <= 43; n++) begin
            BTN = (n == 1 || n == 3 || (n >= 5 && n <= 24) || n == 26 || n == 28);
            tick_clk;
            obs      = {A, B, C};
            exp_cnt  = (n >= 11) ? 3'd1 : 3'd0;
            exp_tick = (n == 11);
            if (TICK === 1'b1) ticks_seen++;
            checks++;
            if (obs !== exp_cnt || TICK !== exp_tick) begin
                errors++;
                $display("FAIL manual_bounce edge=%0d count=%0d tick=%b want %0d/%b",
                         n, obs, TICK, exp_cnt, exp_tick);
            end
        end
        checks++;
        if (ticks_seen != 1) begin
            errors++;
            $display("FAIL manual_bounce_ticks got=%0d want=1", ticks_seen);
        end
        $display("test_manual_bounce done");
    endtask

    task automatic test_manual_short;
        logic [2:0] obs;
        logic [2:0] exp_cnt;
        logic       exp_tick;
        for (int n = 1; n <= 13; n++) begin
            BTN = (n <= 3);
            tick_clk;
            obs = {A, B, C};
            checks++;
            if (obs !== 3'd1 || TICK !== 1'b0) begin
                errors++;
                $display("FAIL manual_short edge=%0d count=%0d tick=%b want 1/0", n, obs, TICK);
            end
        end
        BTN = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick_clk;
            obs      = {A, B, C};
            exp_cnt  = (n >= 7) ? 3'd2 : 3'd1;
            exp_tick = (n == 7);
            checks++;
            if (obs !== exp_cnt || TICK !== exp_tick) begin
                errors++;
                $display("FAIL manual_steady edge=%0d count=%0d tick=%b want %0d/%b",
                         n, obs, TICK, exp_cnt, exp_tick);
            end
        end
        BTN = 1'b0;
        for (int n = 1; n <= 10; n++) tick_clk;
        obs = {A, B, C};
        checks++;
        if (obs !== 3'd2) begin
            errors++;
            $display("FAIL manual_release got=%0d want=2", obs);
        end
        $display("test_manual_short done");
    endtask

    task automatic test_reset_mid;
        logic [2:0] obs;
        logic [2:0] exp_cnt;
        logic       exp_tick;
        // Reset while the debouncer sits in CHK_P.
        MODE = 1'b1; EN = 1'b1; UP = 1'b1; BTN = 1'b1;
        for (int n = 1; n <= 4; n++) tick_clk;
        rst = 1'b1;
        tick_clk;
        obs = {A, B, C};
        checks++;
        if (obs !== 3'd0 || TICK !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_chk_p count=%0d tick=%b want 0/0", obs, TICK);
        end
        rst = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            tick_clk;
            obs      = {A, B, C};
            exp_cnt  = (r >= 7) ? 3'd1 : 3'd0;
            exp_tick = (r == 7);
            checks++;
            if (obs !== exp_cnt || TICK !== exp_tick) begin
                errors++;
                $display("FAIL after_reset_debounce edge=%0d count=%0d tick=%b want %0d/%b",
                         r, obs, TICK, exp_cnt, exp_tick);
            end
        end
        BTN = 1'b0;
        for (int n = 1; n <= 10; n++) tick_clk;
        // Reset while the prescaler holds DIV-1.
        MODE = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick_clk;
            obs = {A, B, C};
            checks++;
            if (obs !== 3'd1 || TICK !== 1'b0) begin
                errors++;
                $display("FAIL prescale_lead edge=%0d count=%0d tick=%b want 1/0", e, obs, TICK);
            end
        end
        rst = 1'b1;
        tick_clk;
        obs = {A, B, C};
        checks++;
        if (obs !== 3'd0 || TICK !== 1'b0) begin
            errors++;
            $display("FAIL reset_at_pre_max count=%0d tick=%b want 0/0", obs, TICK);
        end
        rst = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            tick_clk;
            obs      = {A, B, C};
            exp_cnt  = (r >= 4) ? 3'd1 : 3'd0;
            exp_tick = (r == 4);
            checks++;
            if (obs !== exp_cnt || TICK !== exp_tick) begin
                errors++;
                $display("FAIL after_reset_prescale edge=%0d count=%0d tick=%b want %0d/%b",
                         r, obs, TICK, exp_cnt, exp_tick);
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_press_while_disabled;
        logic [2:0] obs;
        MODE = 1'b1; EN = 1'b0; BTN = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            if (n == 13) EN = 1'b1;
            if (n == 21) BTN = 1'b0;
            tick_clk;
            obs = {A, B, C};
            checks++;
            if (obs !== 3'd1 || TICK !== 1'b0) begin
                errors++;
                $display("FAIL press_disabled edge=%0d count=%0d tick=%b want 1/0", n, obs, TICK);
            end
        end
        $display("test_press_while_disabled done");
    endtask

    initial begin
        test_reset;
        test_auto_up;
        test_auto_down_freeze;
        test_manual_bounce;
        test_manual_short;
        test_reset_mid;
        test_press_while_disabled;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
